// File: rtl/irq_pkg.sv
// Shared constants for the interrupt arbiter: register map, FSM encodings,
// CLAIM result layout and the fixed-priority encoder.
package irq_pkg;

  // Register addresses
  localparam logic [1:0] AddrPending = 2'd0;
  localparam logic [1:0] AddrMask    = 2'd1;
  localparam logic [1:0] AddrClaim   = 2'd2;
  localparam logic [1:0] AddrStatus  = 2'd3;

  // FSM state encodings (code 3 is illegal and recovers to StIdle)
  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StAssert  = 2'd1;
  localparam logic [1:0] StHoldoff = 2'd2;

  // Bit of the CLAIM read data that flags a valid source id
  localparam int unsigned ClaimVldBit = 7;

  // Fixed priority: the lowest set index wins. Returns 0 for an empty set.
  function automatic logic [2:0] prio_id(input logic [7:0] act);
    logic [2:0] id;
    id = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (act[i]) id = 3'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// One request line: two-flop synchroniser followed by a rising-edge detector.
//   i_clk  : system clock
//   i_rst  : synchronous active-high reset
//   i_d    : asynchronous level input
//   o_rise : one-cycle pulse when the synchronised level goes 0 -> 1
module irq_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_s1   <= i_d;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  // Clearing r_prev in reset makes a line held high through reset produce
  // exactly one edge after release.
  assign o_rise = r_s2 & ~r_prev;

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: collects NSRC request lines into pending bits, masks
// them, and drives a single registered interrupt level. Software claims the
// lowest-index active source through a small register port; after each
// claim or drain the output is held low for HOLDOFF ncycle-high clocks so
// the downstream edge detector always sees a fresh rising edge.
//   i_clk    : system clock
//   i_rst    : synchronous active-high reset
//   i_ncycle : low on the second clock of a two-cycle instruction
//   i_src    : raw asynchronous level-high requests
//   i_sel    : register access strobe
//   i_we     : write (1) / read (0), qualified by i_sel
//   i_addr   : register select (PENDING, MASK, CLAIM, STATUS)
//   i_wdata  : write data
//   o_rdata  : registered read data, held until the next read
//   o_int    : interrupt request level
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int unsigned NSRC    = 8,
  parameter int unsigned HOLDOFF = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ncycle,
  input  logic [NSRC-1:0] i_src,
  input  logic            i_sel,
  input  logic            i_we,
  input  logic [1:0]      i_addr,
  input  logic [7:0]      i_wdata,
  output logic [7:0]      o_rdata,
  output logic            o_int
);

  logic [NSRC-1:0] w_rise;
  logic [NSRC-1:0] r_pending;
  logic [NSRC-1:0] r_mask;
  logic [NSRC-1:0] w_active;
  logic [NSRC-1:0] w_clr;
  logic            w_any;
  logic [2:0]      w_id;
  logic            w_rd;
  logic            w_wr;
  logic            w_claim;
  logic [7:0]      w_rdata;
  logic [7:0]      r_rdata;
  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_nxt;
  logic            r_int;

  for (genvar g = 0; g < NSRC; g++) begin : g_sync
    irq_sync u_sync (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_d    (i_src[g]),
      .o_rise (w_rise[g])
    );
  end

  assign w_active = r_pending & r_mask;
  assign w_any    = |w_active;
  assign w_id     = prio_id(8'(w_active));

  assign w_rd    = i_sel & ~i_we;
  assign w_wr    = i_sel & i_we;
  assign w_claim = w_rd && (i_addr == AddrClaim) && w_any;

  // Clear sources: W1C on PENDING and the bit granted by a valid claim
  always_comb begin
    w_clr = '0;
    if (w_wr && (i_addr == AddrPending)) w_clr = i_wdata[NSRC-1:0];
    if (w_claim) w_clr = w_clr | (NSRC'(1) << w_id);
  end

  // Read mux; bits at or above NSRC stay zero
  always_comb begin
    w_rdata = '0;
    unique case (i_addr)
      AddrPending: w_rdata[NSRC-1:0] = r_pending;
      AddrMask:    w_rdata[NSRC-1:0] = r_mask;
      AddrClaim: begin
        if (w_any) begin
          w_rdata[ClaimVldBit] = 1'b1;
          w_rdata[2:0]         = w_id;
        end
      end
      AddrStatus:  w_rdata[2:0] = {r_state, r_int};
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      StIdle: begin
        if (w_any) w_state_nxt = StAssert;
      end
      StAssert: begin
        if (w_claim || !w_any) begin
          w_state_nxt = StHoldoff;
          w_cnt_nxt   = 4'd0;
        end
      end
      StHoldoff: begin
        // Stalled clocks of two-cycle instructions do not count
        if (i_ncycle) begin
          w_cnt_nxt = r_cnt + 4'd1;
          if (r_cnt + 4'd1 == 4'(HOLDOFF)) w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending <= '0;
      r_mask    <= '0;
      r_rdata   <= 8'h00;
      r_state   <= StIdle;
      r_cnt     <= 4'd0;
      r_int     <= 1'b0;
    end else begin
      // A new edge wins over a simultaneous clear so no event is lost
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (w_wr && (i_addr == AddrMask)) r_mask <= i_wdata[NSRC-1:0];
      if (w_rd) r_rdata <= w_rdata;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      // Decoded from next state so the output comes straight from a flop
      r_int   <= (w_state_nxt == StAssert);
    end
  end

  assign o_rdata = r_rdata;
  assign o_int   = r_int;

endmodule

// File: tb/tb_irq_arbiter.sv
module tb_irq_arbiter;

  localparam int unsigned NSRC    = 8;
  localparam int unsigned HOLDOFF = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       ncycle;
  logic [7:0] src;
  logic       sel;
  logic       we;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  irq_arbiter #(
    .NSRC    (NSRC),
    .HOLDOFF (HOLDOFF)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_ncycle (ncycle),
    .i_src    (src),
    .i_sel    (sel),
    .i_we     (we),
    .i_addr   (addr),
    .i_wdata  (wdata),
    .o_rdata  (rdata),
    .o_int    (irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick();
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    sel = 1'b1; we = 1'b0; addr = a;
    tick();
    sel = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ncycle = 1'b1; src = 8'h00;
    sel = 1'b0; we = 1'b0; addr = 2'd0; wdata = 8'h00;
    tick(); tick();
    rst = 1'b0;
    chk("reset_int", {7'b0, irq}, 8'h00);
    chk("reset_rdata", rdata, 8'h00);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a));
      chk($sformatf("reset_rd%0d", a), rdata, 8'h00);
      chk($sformatf("reset_rd%0d_int", a), {7'b0, irq}, 8'h00);
    end

    // Single source, latency and claim
    wr(2'd1, 8'h05);
    rd(2'd1);
    chk("mask_rb", rdata, 8'h05);
    src[2] = 1'b1;
    tick(); chk("lat_k", {7'b0, irq}, 8'h00);
    tick(); chk("lat_k1", {7'b0, irq}, 8'h00);
    tick(); chk("lat_k2", {7'b0, irq}, 8'h00);
    src[2] = 1'b0;
    tick(); chk("lat_k3", {7'b0, irq}, 8'h01);
    rd(2'd2);
    chk("claim1", rdata, 8'h82);
    chk("claim1_int", {7'b0, irq}, 8'h00);
    rd(2'd0);
    chk("pend_after_claim1", rdata, 8'h00);
    repeat (3) tick();

    // Two simultaneous sources, holdoff with ncycle high
    wr(2'd1, 8'hFF);
    src = 8'h05;
    repeat (3) tick();
    chk("two_pre", {7'b0, irq}, 8'h00);
    tick();
    chk("two_assert", {7'b0, irq}, 8'h01);
    rd(2'd2);
    chk("claim_a", rdata, 8'h80);
    chk("claim_a_int", {7'b0, irq}, 8'h00);
    tick(); chk("hold_c1", {7'b0, irq}, 8'h00);
    tick(); chk("hold_c2", {7'b0, irq}, 8'h00);
    tick(); chk("reassert_c3", {7'b0, irq}, 8'h01);
    rd(2'd2);
    chk("claim_b", rdata, 8'h82);
    chk("claim_b_int", {7'b0, irq}, 8'h00);
    rd(2'd2);
    chk("claim_empty", rdata, 8'h00);
    rd(2'd0);
    chk("pend_empty", rdata, 8'h00);
    rd(2'd3);
    chk("status_idle", rdata, 8'h00);
    src = 8'h00;
    repeat (3) tick();

    // ncycle low for two holdoff clocks delays reassertion by two
    src = 8'h03;
    repeat (4) tick();
    chk("nc_assert", {7'b0, irq}, 8'h01);
    rd(2'd3);
    chk("status_assert", rdata, 8'h03);
    rd(2'd2);
    chk("nc_claim", rdata, 8'h80);
    ncycle = 1'b0;
    rd(2'd3);
    chk("status_holdoff", rdata, 8'h04);
    tick();
    ncycle = 1'b1;
    tick(); chk("nc_c3", {7'b0, irq}, 8'h00);
    tick(); chk("nc_c4", {7'b0, irq}, 8'h00);
    tick(); chk("nc_c5", {7'b0, irq}, 8'h01);
    rd(2'd2);
    chk("nc_claim2", rdata, 8'h81);
    src = 8'h00;
    repeat (4) tick();

    // Masked pending, W1C, set/clear collision, read-only registers
    wr(2'd1, 8'h00);
    src[3] = 1'b1; tick();
    src[3] = 1'b0; tick(); tick();
    rd(2'd0);
    chk("pend_masked", rdata, 8'h08);
    chk("masked_no_int", {7'b0, irq}, 8'h00);
    wr(2'd0, 8'h08);
    rd(2'd0);
    chk("w1c", rdata, 8'h00);
    src[3] = 1'b1;
    tick(); tick();
    wr(2'd0, 8'h08);
    rd(2'd0);
    chk("collision", rdata, 8'h08);
    wr(2'd0, 8'h08);
    rd(2'd0);
    chk("w1c_after_collision", rdata, 8'h00);
    src = 8'h00;
    wr(2'd3, 8'hFF);
    rd(2'd3);
    chk("status_ro", rdata, 8'h00);
    tick(); tick();

    // Reset while asserted, held source re-registers once
    wr(2'd1, 8'hFF);
    src = 8'h11;
    repeat (4) tick();
    chk("pre_rst_int", {7'b0, irq}, 8'h01);
    rd(2'd0);
    chk("pre_rst_pend", rdata, 8'h11);
    rst = 1'b1;
    tick();
    chk("rst_int", {7'b0, irq}, 8'h00);
    chk("rst_rdata", rdata, 8'h00);
    rst = 1'b0;
    rd(2'd3);
    chk("rst_status", rdata, 8'h00);
    rd(2'd0);
    chk("rst_pend", rdata, 8'h00);
    tick();
    rd(2'd0);
    chk("rereg", rdata, 8'h11);
    rd(2'd1);
    chk("rst_mask", rdata, 8'h00);
    wr(2'd0, 8'h11);
    repeat (3) tick();
    rd(2'd0);
    chk("held_once", rdata, 8'h00);
    chk("final_int", {7'b0, irq}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
